// File: rtl/fu_wb_pkg.sv
// Shared write-back parameters and FU index constants.
// Used by issue logic, scoreboard and the write-back arbiter.
package fu_wb_pkg;
  localparam int N_FU  = 5;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam int IDX_W = 3;

  localparam logic [IDX_W-1:0] FU_ALU  = 3'd0;
  localparam logic [IDX_W-1:0] FU_MEM  = 3'd1;
  localparam logic [IDX_W-1:0] FU_MUL  = 3'd2;
  localparam logic [IDX_W-1:0] FU_DIV  = 3'd3;
  localparam logic [IDX_W-1:0] FU_JUMP = 3'd4;

  typedef struct packed {
    logic [TAG_W-1:0] rd;
    logic [XLEN-1:0]  res;
  } wb_slot_t;
endpackage

// File: rtl/fu_wb_arbiter_rr.sv
// Round-robin arbiter: first request at or after the pointer wins.
// The pointer moves past the winner only when advance is asserted.
module rr_arbiter #(
  parameter int N  = 5,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  int            j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_q) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance)
      ptr_d = (idx == IW'(N-1)) ? '0 : idx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/fu_wb_arbiter.sv
// Write-back stage: one result slot per FU, round-robin onto a
// single valid/ready write-back bus with a grant lock under stall.
module fu_wb_arbiter
  import fu_wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_FU-1:0]       fu_finish,
  input  logic [N_FU*XLEN-1:0]  fu_res,
  input  logic [N_FU*TAG_W-1:0] fu_rd,
  output logic [N_FU-1:0]       slot_full,
  output logic                  wb_valid,
  output logic [IDX_W-1:0]      wb_fu,
  output logic [TAG_W-1:0]      wb_rd,
  output logic [XLEN-1:0]       wb_data,
  input  logic                  wb_ready,
  output logic                  overflow
);
  logic [N_FU-1:0]  full_q, full_d;
  wb_slot_t         slot_q [N_FU];
  wb_slot_t         slot_d [N_FU];
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lk_q, lk_d;
  logic             ovf_q, ovf_d;

  logic [N_FU-1:0]  req, gnt, retire;
  logic [IDX_W-1:0] g_idx;
  logic             hs;
  wb_slot_t         sel;

  // A stalled grant is pinned by presenting only that slot
  assign req = lock_q ? (N_FU'(1) << lk_q) : full_q;

  rr_arbiter #(.N(N_FU), .IW(IDX_W)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (hs),
    .gnt     (gnt),
    .idx     (g_idx)
  );

  assign wb_valid  = |full_q;
  assign hs        = wb_valid & wb_ready;
  assign retire    = hs ? gnt : '0;
  assign slot_full = full_q;
  assign overflow  = ovf_q;

  always_comb begin
    sel = '0;
    for (int i = 0; i < N_FU; i++)
      if (gnt[i]) sel = slot_q[i];
  end

  assign wb_fu   = g_idx;
  assign wb_rd   = sel.rd;
  assign wb_data = sel.res;

  always_comb begin
    full_d = full_q;
    slot_d = slot_q;
    ovf_d  = ovf_q;
    for (int i = 0; i < N_FU; i++) begin
      if (retire[i]) full_d[i] = 1'b0;
      if (fu_finish[i]) begin
        if (!full_q[i] || retire[i]) begin
          full_d[i]     = 1'b1;
          slot_d[i].rd  = fu_rd[i*TAG_W +: TAG_W];
          slot_d[i].res = fu_res[i*XLEN +: XLEN];
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
    lock_d = wb_valid & ~wb_ready;
    lk_d   = lock_d ? g_idx : lk_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= '0;
      lock_q <= 1'b0;
      lk_q   <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < N_FU; i++)
        slot_q[i] <= '0;
    end else begin
      full_q <= full_d;
      lock_q <= lock_d;
      lk_q   <= lk_d;
      ovf_q  <= ovf_d;
      for (int i = 0; i < N_FU; i++)
        slot_q[i] <= slot_d[i];
    end
  end
endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Directed bench for fu_wb_arbiter with a per-cycle slot model
// plus hand-computed expectations for each scenario.
module tb_fu_wb_arbiter;
  import fu_wb_pkg::*;

  logic                  clk;
  logic                  rst;
  logic [N_FU-1:0]       fu_finish;
  logic [N_FU*XLEN-1:0]  fu_res;
  logic [N_FU*TAG_W-1:0] fu_rd;
  logic [N_FU-1:0]       slot_full;
  logic                  wb_valid;
  logic [IDX_W-1:0]      wb_fu;
  logic [TAG_W-1:0]      wb_rd;
  logic [XLEN-1:0]       wb_data;
  logic                  wb_ready;
  logic                  overflow;

  fu_wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .fu_finish (fu_finish),
    .fu_res    (fu_res),
    .fu_rd     (fu_rd),
    .slot_full (slot_full),
    .wb_valid  (wb_valid),
    .wb_fu     (wb_fu),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .wb_ready  (wb_ready),
    .overflow  (overflow)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: each FU owns a one-entry mailbox; the bus shows one
  // mailbox, held until accepted; acceptance moves the start point.
  bit          m_full [N_FU];
  logic [31:0] m_res  [N_FU];
  logic [4:0]  m_rd   [N_FU];
  int          m_ptr  = 0;
  bit          m_lock = 0;
  int          m_lockg = 0;
  bit          m_ovf  = 0;

  function automatic int m_grant();
    if (m_lock) return m_lockg;
    for (int k = 0; k < N_FU; k++)
      if (m_full[(m_ptr + k) % N_FU]) return (m_ptr + k) % N_FU;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_FU; i++) begin
        m_full[i] = 0;
        m_res[i]  = '0;
        m_rd[i]   = '0;
      end
      m_ptr  = 0;
      m_lock = 0;
      m_ovf  = 0;
    end else begin
      int g;
      g = m_grant();
      if (g >= 0 && wb_ready) begin
        m_full[g] = 0;
        m_ptr     = (g + 1) % N_FU;
        m_lock    = 0;
      end else if (g >= 0) begin
        m_lock  = 1;
        m_lockg = g;
      end
      for (int i = 0; i < N_FU; i++)
        if (fu_finish[i]) begin
          if (!m_full[i]) begin
            m_full[i] = 1;
            m_res[i]  = fu_res[i*XLEN +: XLEN];
            m_rd[i]   = fu_rd[i*TAG_W +: TAG_W];
          end else begin
            m_ovf = 1;
          end
        end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      int g;
      logic [N_FU-1:0] ef;
      g = m_grant();
      for (int i = 0; i < N_FU; i++) ef[i] = m_full[i];
      chk("m_slot_full", 64'(slot_full), 64'(ef));
      chk("m_wb_valid", 64'(wb_valid), 64'(g >= 0));
      chk("m_wb_fu", 64'(wb_fu), (g >= 0) ? 64'(g) : 64'd0);
      chk("m_wb_rd", 64'(wb_rd), (g >= 0) ? 64'(m_rd[g]) : 64'd0);
      chk("m_wb_data", 64'(wb_data), (g >= 0) ? 64'(m_res[g]) : 64'd0);
      chk("m_overflow", 64'(overflow), 64'(m_ovf));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fin(input int i, input logic [31:0] r,
                     input logic [4:0] d);
    fu_finish[i]          = 1'b1;
    fu_res[i*XLEN +: XLEN] = r;
    fu_rd[i*TAG_W +: TAG_W] = d;
  endtask

  task automatic clr();
    fu_finish = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    fu_finish = '0;
    fu_res    = '0;
    fu_rd     = '0;
    wb_ready  = 1'b0;
    #12;
    chk("rst_valid", 64'(wb_valid), 64'd0);
    chk("rst_full", 64'(slot_full), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    step();
    rst = 1'b0;

    // 1: single MUL result
    wb_ready = 1'b1;
    fin(2, 32'h0000_00A5, 5'd7);
    step(); clr();
    chk("t1_valid", 64'(wb_valid), 64'd1);
    chk("t1_fu", 64'(wb_fu), 64'd2);
    chk("t1_rd", 64'(wb_rd), 64'd7);
    chk("t1_data", 64'(wb_data), 64'hA5);
    step();
    chk("t1_valid_off", 64'(wb_valid), 64'd0);
    chk("t1_full_off", 64'(slot_full), 64'd0);

    // 2: round-robin 0,2,4 twice
    do_reset();
    wb_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      fin(0, 32'h100 + 32'(r), 5'd1);
      fin(2, 32'h102 + 32'(r), 5'd3);
      fin(4, 32'h104 + 32'(r), 5'd5);
      step(); clr();
      chk("t2_g0", 64'(wb_fu), 64'd0);
      step();
      chk("t2_g2", 64'(wb_fu), 64'd2);
      step();
      chk("t2_g4", 64'(wb_fu), 64'd4);
      chk("t2_d4", 64'(wb_data), 64'(32'h104 + 32'(r)));
      step();
      chk("t2_idle", 64'(wb_valid), 64'd0);
    end

    // 3: backpressure locks grant on slot 3
    wb_ready = 1'b0;
    fin(3, 32'h333, 5'd9);
    step(); clr();
    chk("t3_fu", 64'(wb_fu), 64'd3);
    fin(1, 32'h111, 5'd2);
    step(); clr();
    for (int c = 0; c < 3; c++) begin
      chk("t3_hold_fu", 64'(wb_fu), 64'd3);
      chk("t3_hold_d", 64'(wb_data), 64'h333);
      chk("t3_hold_rd", 64'(wb_rd), 64'd9);
      step();
    end
    wb_ready = 1'b1;
    step();
    chk("t3_next_fu", 64'(wb_fu), 64'd1);
    chk("t3_next_d", 64'(wb_data), 64'h111);
    step();
    chk("t3_idle", 64'(wb_valid), 64'd0);

    // 4: drain and refill slot 0
    wb_ready = 1'b0;
    fin(0, 32'hAAAA, 5'd4);
    step(); clr();
    chk("t4_first", 64'(wb_data), 64'hAAAA);
    wb_ready = 1'b1;
    fin(0, 32'h1234, 5'd6);
    step(); clr();
    chk("t4_full0", 64'(slot_full[0]), 64'd1);
    chk("t4_data", 64'(wb_data), 64'h1234);
    chk("t4_rd", 64'(wb_rd), 64'd6);
    chk("t4_ovf", 64'(overflow), 64'd0);
    step();
    chk("t4_idle", 64'(wb_valid), 64'd0);

    // 5: overflow on slot 4
    wb_ready = 1'b0;
    fin(4, 32'hBEEF, 5'd8);
    step(); clr();
    chk("t5_fu", 64'(wb_fu), 64'd4);
    fin(4, 32'hDEAD, 5'd9);
    step(); clr();
    chk("t5_ovf", 64'(overflow), 64'd1);
    chk("t5_keep_d", 64'(wb_data), 64'hBEEF);
    chk("t5_keep_rd", 64'(wb_rd), 64'd8);
    step();
    wb_ready = 1'b1;
    step();
    chk("t5_idle", 64'(wb_valid), 64'd0);
    chk("t5_sticky", 64'(overflow), 64'd1);

    // 6: async reset with three slots full
    do_reset();
    wb_ready = 1'b0;
    fin(1, 32'h11, 5'd1);
    fin(2, 32'h22, 5'd2);
    fin(3, 32'h33, 5'd3);
    step(); clr();
    chk("t6_pre_fu", 64'(wb_fu), 64'd1);
    step();
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", 64'(wb_valid), 64'd0);
    chk("t6_full", 64'(slot_full), 64'd0);
    chk("t6_data", 64'(wb_data), 64'd0);
    chk("t6_rd", 64'(wb_rd), 64'd0);
    chk("t6_fu", 64'(wb_fu), 64'd0);
    step();
    rst = 1'b0;
    wb_ready = 1'b1;
    step();
    chk("t6_no_old", 64'(wb_valid), 64'd0);
    fin(0, 32'h55, 5'd10);
    fin(3, 32'h66, 5'd11);
    step(); clr();
    chk("t6_g0", 64'(wb_fu), 64'd0);
    step();
    chk("t6_g3", 64'(wb_fu), 64'd3);
    chk("t6_d3", 64'(wb_data), 64'h66);
    step();
    chk("t6_idle", 64'(wb_valid), 64'd0);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
